// File: rtl/fetch_unit_pkg.sv
// Shared constants and redirect-priority encoding for the instruction fetch front end.
package fetch_unit_pkg;

    localparam logic [31:0] PC_START  = 32'h0000_1000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_IRQ    = 2'd3
    } redir_sel_e;

    function automatic redir_sel_e redir_select(input logic irq, input logic jmp, input logic br);
        if (irq) return REDIR_IRQ;
        if (jmp) return REDIR_JUMP;
        if (br)  return REDIR_BRANCH;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; any DEPTH >= 1.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Index wraps at DEPTH (not 2**AW) and the extra MSB toggles on each wrap.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
        return p + (AW + 1)'(1);
    endfunction

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        if (wr_ptr_q[AW] == rd_ptr_q[AW])
            count = CW'(wr_ptr_q[AW-1:0]) - CW'(rd_ptr_q[AW-1:0]);
        else
            count = CW'(DEPTH) - CW'(rd_ptr_q[AW-1:0]) + CW'(wr_ptr_q[AW-1:0]);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: PC, credit-limited requests, prefetch queue, redirect flush.
// Optional combinational empty-queue bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(PC_START)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            interrupt,
    input  logic [XLEN-1:0] evec,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] fetch_addr,
    output logic            fetch_request,
    input  logic            fetch_ready,
    input  logic            fetch_data_valid,
    input  logic [XLEN-1:0] fetch_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int QCW = $clog2(DEPTH + 1);
    localparam int SCW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [SCW-1:0]    discard_q, discard_d;
    logic              redirect;
    logic [XLEN-1:0]   redirect_target;
    logic              accept, resp, keep, bypass;

    logic [SCW-1:0]    outstanding;
    logic              sh_full, sh_empty;
    logic [XLEN-1:0]   sh_head;

    logic [QCW-1:0]    q_count;
    logic              q_full, q_empty, q_push, q_pop;
    logic [2*XLEN-1:0] q_head;

    always_comb begin
        redirect = interrupt | jump_taken | branch_taken;
        case (redir_select(interrupt, jump_taken, branch_taken))
            REDIR_IRQ:  redirect_target = evec;
            REDIR_JUMP: redirect_target = jump_target;
            default:    redirect_target = branch_target;
        endcase
    end

    // Outstanding counts every accepted request, including ones already marked for discard.
    assign fetch_request = !reset && !redirect && !sh_full && !q_full
                           && (32'(outstanding) + 32'(q_count) < 32'(DEPTH));
    assign fetch_addr    = fetch_pc_q;
    assign accept        = fetch_request & fetch_ready;
    assign resp          = fetch_data_valid & ~sh_empty & ~reset;
    assign keep          = resp & ~redirect & (discard_q == '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
            discard_d  = outstanding - SCW'(resp);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (resp && discard_q != '0) discard_d = discard_q - SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = keep & q_empty;
`else
        bypass = 1'b0;
`endif
        inst_valid = ~q_empty | bypass;
        if (!q_empty) begin
            inst    = q_head[2*XLEN-1:XLEN];
            inst_pc = q_head[XLEN-1:0];
        end else if (bypass) begin
            inst    = fetch_data;
            inst_pc = sh_head;
        end else begin
            inst    = XLEN'(INSTR_NOP);
            inst_pc = RESET_PC;
        end
        q_pop  = ~q_empty & inst_ready;
        q_push = keep & ~(bypass & inst_ready);
    end

    // Address shadow: one entry per in-flight request, popped by every response.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_shadow (
        .clk       (clk),
        .srst      (reset),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (resp),
        .flush     (1'b0),
        .head_data (sh_head),
        .count     (outstanding),
        .full      (sh_full),
        .empty     (sh_empty)
    );

    fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_inst_queue (
        .clk       (clk),
        .srst      (reset),
        .push      (q_push),
        .push_data ({fetch_data, sh_head}),
        .pop       (q_pop),
        .flush     (redirect),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and an expected-PC-stream model.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt, jump_taken, branch_taken;
    logic [31:0] evec, jump_target, branch_target;
    logic [31:0] fetch_addr;
    logic        fetch_request, fetch_ready;
    logic        fetch_data_valid;
    logic [31:0] fetch_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .interrupt        (interrupt),
        .evec             (evec),
        .jump_taken       (jump_taken),
        .jump_target      (jump_target),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .fetch_addr       (fetch_addr),
        .fetch_request    (fetch_request),
        .fetch_ready      (fetch_ready),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_ready       (inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    int          n_checks = 0, n_pass = 0;
    int          n_pops = 0, n_accepts = 0, m_inflight = 0;
    logic [31:0] m_fetch_pc, m_exp_pc;
    logic        s_req, s_ival;
    logic [31:0] s_addr, s_inst, s_ipc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // One clock: drive the memory response, sample, check against the models, advance.
    task automatic run_cycle();
        logic        redir;
        logic [31:0] tgt;
        req_t        r;
        fetch_data_valid = 1'b0;
        fetch_data       = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            fetch_data_valid = 1'b1;
            fetch_data       = mem_word(mem_q[0].addr);
        end
        #1;
        s_req  = fetch_request;
        s_addr = fetch_addr;
        s_ival = inst_valid;
        s_inst = inst;
        s_ipc  = inst_pc;
        redir  = interrupt | jump_taken | branch_taken;
        if (s_req) begin
            check_val("req_addr", s_addr, m_fetch_pc);
            check_val("req_credit", m_inflight < MAXO, 1);
        end
        if (redir) check_val("redir_noreq", s_req, 0);
        if (s_ival && inst_ready) begin
            $display("pop  pc=%08h inst=%08h", s_ipc, s_inst);
            check_val("pop_pc", s_ipc, m_exp_pc);
            check_val("pop_inst", s_inst, mem_word(m_exp_pc));
            m_exp_pc += 32'd4;
            n_pops++;
        end
        if (fetch_data_valid) begin
            void'(mem_q.pop_front());
            m_inflight--;
        end
        if (s_req && fetch_ready) begin
            r.addr = s_addr;
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            mem_q.push_back(r);
            m_fetch_pc += 32'd4;
            m_inflight++;
            n_accepts++;
        end
        if (redir) begin
            tgt        = interrupt ? evec : (jump_taken ? jump_target : branch_target);
            m_fetch_pc = tgt;
            m_exp_pc   = tgt;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        interrupt        = 1'b0;
        jump_taken       = 1'b0;
        branch_taken     = 1'b0;
        evec             = '0;
        jump_target      = '0;
        branch_target    = '0;
        fetch_ready      = 1'b0;
        fetch_data_valid = 1'b0;
        fetch_data       = '0;
        inst_ready       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req", fetch_request, 0);
        check_val("rst_addr", fetch_addr, RST_PC);
        check_val("rst_ival", inst_valid, 0);
        check_val("rst_inst", inst, NOP);
        check_val("rst_ipc", inst_pc, RST_PC);
        reset = 1'b0;
        mem_q.delete();
        m_fetch_pc = RST_PC;
        m_exp_pc   = RST_PC;
        m_inflight = 0;
        last_due   = cyc;
    endtask

    initial begin
        int p0, a0, k;

        // Streaming with single-cycle memory.
        do_reset();
        lat_min = 1; lat_max = 1;
        fetch_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check_val("seq_req", s_req, 1);
            check_val("seq_addr", s_addr, RST_PC + 32'(4 * i));
        end
        p0 = n_pops;
        repeat (20) run_cycle();
        check_val("throughput", n_pops - p0, 20);

        // Decode stall: queue fills to DEPTH, then drains in order.
        do_reset();
        fetch_ready = 1'b1; inst_ready = 1'b0;
        a0 = n_accepts;
        run_cycle();
        run_cycle();
        check_val("lat_resp_valid", s_ival, BYP);
        check_val("lat_resp_inst", s_inst, BYP ? 32'hDEAD_BEEF : NOP);
        run_cycle();
        check_val("lat_next_valid", s_ival, 1);
        check_val("lat_next_inst", s_inst, 32'hDEAD_BEEF);
        check_val("lat_next_pc", s_ipc, RST_PC);
        repeat (7) run_cycle();
        check_val("stall_accepts", n_accepts - a0, DEPTH);
        check_val("stall_req_low", s_req, 0);
        inst_ready = 1'b1;
        p0 = n_pops;
        repeat (12) run_cycle();
        check_val("stall_drain", (n_pops - p0) >= DEPTH, 1);

        // Jump with two requests in flight on a 2-cycle memory.
        do_reset();
        lat_min = 2; lat_max = 2;
        fetch_ready = 1'b1; inst_ready = 1'b1;
        for (k = 0; k < 20 && m_inflight != 2; k++) run_cycle();
        check_val("jump_setup", m_inflight, 2);
        jump_taken = 1'b1; jump_target = 32'h0000_0100;
        run_cycle();
        jump_taken = 1'b0;
        run_cycle();
        check_val("jump_addr", s_addr, 32'h0000_0100);
        check_val("jump_flush", s_ival, 0);
        p0 = n_pops;
        repeat (10) run_cycle();
        check_val("jump_resume", n_pops > p0, 1);

        // Interrupt beats a simultaneous branch.
        interrupt = 1'b1; evec = 32'h0000_0080;
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        run_cycle();
        interrupt = 1'b0; branch_taken = 1'b0;
        run_cycle();
        check_val("prio_addr", s_addr, 32'h0000_0080);
        repeat (8) run_cycle();

        // Redirect in the same cycle a response arrives.
        do_reset();
        lat_min = 1; lat_max = 1;
        fetch_ready = 1'b1; inst_ready = 1'b1;
        repeat (5) run_cycle();
        branch_taken = 1'b1; branch_target = 32'h0000_0300;
        run_cycle();
        branch_taken = 1'b0;
        check_val("rr_resp_in_redir", fetch_data_valid, 1);
        run_cycle();
        check_val("rr_no_stale", s_ival, 0);
        check_val("rr_addr", s_addr, 32'h0000_0300);
        p0 = n_pops;
        repeat (6) run_cycle();
        check_val("rr_resume", n_pops > p0, 1);

        // Randomized traffic, back-pressure and redirects.
        do_reset();
        lat_min = 1; lat_max = 3;
        p0 = n_pops;
        for (int i = 0; i < 800; i++) begin
            int          r;
            logic [2:0]  m;
            inst_ready  = ($urandom_range(0, 3) != 0);
            fetch_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                m = 3'($urandom_range(1, 7));
                interrupt     = m[2];
                jump_taken    = m[1];
                branch_taken  = m[0];
                evec          = 32'h0000_4000 + 32'($urandom_range(0, 1023) << 4);
                jump_target   = 32'h0001_0000 + 32'($urandom_range(0, 1023) << 4);
                branch_target = 32'h0002_0000 + 32'($urandom_range(0, 1023) << 4);
            end
            run_cycle();
            interrupt = 1'b0; jump_taken = 1'b0; branch_taken = 1'b0;
        end
        inst_ready = 1'b1; fetch_ready = 1'b1;
        repeat (20) run_cycle();
        check_val("rand_progress", (n_pops - p0) > 200, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
